data_mem_access_unit: RTL and testbench
=======================================

Name: data_mem_access_unit

Overview:
- Initiator side of the data-memory interface. Sits between the CPU datapath's load/store path and the word-addressed, single-port data memory. That memory has synchronous write and asynchronous read.
- Converts byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests into word accesses.
- Performs read-modify-write for sub-word stores and sign/zero extension for sub-word loads.
- Flags misaligned and out-of-range requests without touching memory.

Parameters:
- MEM_DEPTH, 64, number of 32-bit words in the data memory.
- WIDX_W, $clog2(MEM_DEPTH), word-index width driven on mem_addr.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  0=byte, 1=half, 2=word; 3 is illegal and treated as misaligned.
- req_signed  in  1  loads only: 1=sign-extend, 0=zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; only the low byte/half is used for sub-word stores.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid; misaligned, illegal size or out-of-range.
- mem_addr  out  WIDX_W  word index to memory.
- mem_wd  out  32  write data to memory.
- mem_we  out  1  write enable to memory.
- mem_rd  in  32  asynchronous read data from memory.

Behaviour:
- Reset, asynchronous on rst_n=0:
  - State goes to IDLE.
  - req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_we=0, mem_addr=0, mem_wd=0.
  - Reset mid-operation abandons the request with no write and no response. mem_we drops immediately, so no partial RMW ever commits.
- Byte lanes are little-endian: byte k of a word is bits [8k+7:8k], with k=addr[1:0].
- Accept: req_valid & req_ready at a rising edge latches all req_* fields. Requests in other states are ignored, since req_ready=0.
- Error check at accept:
  - half with addr[0]=1 is an error.
  - word with addr[1:0]!=0 is an error.
  - size=3 is an error.
  - addr[31:2] >= MEM_DEPTH is an error.
- States: IDLE, ACCESS, MERGE, RESP.
  - IDLE -> ACCESS on a good accept; IDLE -> RESP with resp_err=1 on an error accept.
  - ACCESS:
    - mem_addr = latched addr[WIDX_W+1:2].
    - Load: capture extracted/extended mem_rd into resp_rdata, then go to RESP.
    - Word store: mem_we=1 and mem_wd=req_wdata this cycle, then go to RESP.
    - Sub-word store: capture mem_rd into the merge buffer, then go to MERGE.
  - MERGE:
    - mem_we=1.
    - mem_wd = buffer with the selected byte/half lane(s) replaced by req_wdata[7:0]/[15:0].
    - Go to RESP.
  - RESP: resp_valid=1 for exactly one cycle, then go to IDLE with req_ready=1 the next cycle. There is no response backpressure.
- Latency, counted in rising edges from the accept edge to the edge that ends the resp_valid cycle:
  - error: 2.
  - load or word store: 3.
  - sub-word store: 4.
- mem_we is registered-free combinational from state: high only in store-ACCESS for word stores and in MERGE. mem_wd is 0 whenever mem_we=0.
- Extension: byte/half loads replicate bit 7/15 when req_signed=1, else zero-fill. Word loads ignore req_signed.
- Back-to-back: the earliest next accept is the cycle after RESP. Throughput is one request per 3–4 cycles.

Decomposition:
- Shared package mem_pkg:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD constants.
  - state typedef (IDLE, ACCESS, MERGE, RESP).
  - WORD_W=32.
- One combinational sub-module, lane_align, contains:
  - load extraction/extension: word, addr[1:0], size, signed -> 32-bit result.
  - store merge: old word, new data, addr[1:0], size -> merged word.
- The FSM and registers stay in the top module.

Test Plan:
- Memory word 5 = 0x8844_22F1; LB addr 0x15 (byte 1 = 0x22) -> resp_rdata 0x0000_0022. LB addr 0x14 -> 0xFFFF_FFF1. LBU addr 0x14 -> 0x0000_00F1. In all three, resp_valid fires 3 edges after accept and mem_we stays 0.
- Memory word 5 = 0x8844_22F1; SB addr 0x17, wdata 0xABCD_EF5A -> in MERGE, mem_addr=5, mem_we=1, mem_wd=0x5A44_22F1. A following LW addr 0x14 returns 0x5A44_22F1.
- SW addr 0x20, wdata 0xDEAD_BEEF -> a single mem_we pulse in ACCESS with mem_addr=8 and mem_wd=0xDEAD_BEEF. Then SH addr 0x22 with 0x1234 -> word 8 = 0x1234_BEEF. Then LH addr 0x22 signed -> 0x0000_1234.
- Misaligned and out-of-range cases, each giving resp_err=1, mem_we never 1, and resp 2 edges after accept:
  - LW addr 0x02 (misaligned).
  - LH addr 0x01 (misaligned).
  - SW addr 0x100 (out of range, MEM_DEPTH=64).
  - req_size=3.
- Assert rst_n=0 during MERGE of an SB -> mem_we falls immediately, no write, no resp_valid, target word unchanged. After release, req_ready=1.
- Hold req_valid high continuously with 4 alternating loads/stores -> each is accepted only while req_ready=1, no request is lost or duplicated, and exactly 4 resp_valid pulses occur.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory access path.
package mem_pkg;

    localparam int WORD_W = 32;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        MERGE  = 2'd2,
        RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/data_mem_access_unit_lane_align.sv
// Byte-lane steering: load extraction with sign/zero extension, and
// sub-word store merge into an existing memory word. Purely combinational.
module lane_align
    import mem_pkg::*;
(
    input  logic [WORD_W-1:0] rd_word,
    input  logic [1:0]        offset,
    input  logic [1:0]        size,
    input  logic              is_signed,
    input  logic [WORD_W-1:0] old_word,
    input  logic [WORD_W-1:0] new_data,
    output logic [WORD_W-1:0] load_data,
    output logic [WORD_W-1:0] merge_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Pick the addressed lane out of the read word and extend it to 32 bits.
    always_comb begin
        sel_byte  = rd_word[{offset, 3'b000} +: 8];
        sel_half  = rd_word[{offset[1], 4'b0000} +: 16];
        load_data = rd_word;
        case (size)
            SIZE_BYTE: load_data = {{24{is_signed & sel_byte[7]}}, sel_byte};
            SIZE_HALF: load_data = {{16{is_signed & sel_half[15]}}, sel_half};
            default:   load_data = rd_word;
        endcase
    end

    // Overwrite only the addressed lane(s) of the old word with the store data.
    always_comb begin
        merge_data = old_word;
        case (size)
            SIZE_BYTE: merge_data[{offset, 3'b000} +: 8]     = new_data[7:0];
            SIZE_HALF: merge_data[{offset[1], 4'b0000} +: 16] = new_data[15:0];
            default:   merge_data = new_data;
        endcase
    end

endmodule

// File: rtl/data_mem_access_unit.sv
// Initiator side of the data-memory port: turns byte-addressed CPU
// loads/stores into word accesses, with read-modify-write for sub-word stores.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for a request
// ACCESS | memory addressed; load data captured or word store written
// MERGE  | sub-word store: merged word written back
// RESP   | one-cycle response pulse
module data_mem_access_unit
    import mem_pkg::*;
#(
    parameter int MEM_DEPTH = 64,
    parameter int WIDX_W    = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [WIDX_W-1:0] mem_addr,
    output logic [31:0]       mem_wd,
    output logic              mem_we,
    input  logic [31:0]       mem_rd
);

    state_t              state_q, state_d;
    logic                we_q;
    logic [1:0]          size_q;
    logic                sgn_q;
    logic [WIDX_W+1:0]   addr_q;
    logic [WORD_W-1:0]   wdata_q;
    logic [WORD_W-1:0]   buf_q;
    logic [WORD_W-1:0]   rdata_q;
    logic                err_q;
    logic                accept;
    logic                req_bad;
    logic                is_sub;
    logic [WORD_W-1:0]   load_data;
    logic [WORD_W-1:0]   merge_data;

    assign req_ready  = (state_q == IDLE);
    assign accept     = req_valid & req_ready;
    assign resp_valid = (state_q == RESP);
    assign resp_err   = resp_valid & err_q;
    assign resp_rdata = rdata_q;
    assign mem_addr   = addr_q[WIDX_W+1:2];
    assign is_sub     = (size_q != SIZE_WORD);

    // Alignment, size legality and range check on the incoming request.
    always_comb begin
        req_bad = 1'b0;
        case (req_size)
            SIZE_BYTE: req_bad = 1'b0;
            SIZE_HALF: req_bad = req_addr[0];
            SIZE_WORD: req_bad = |req_addr[1:0];
            default:   req_bad = 1'b1;
        endcase
        if (req_addr[31:2] >= 30'(MEM_DEPTH))
            req_bad = 1'b1;
    end

    lane_align u_lane_align (
        .rd_word    (mem_rd),
        .offset     (addr_q[1:0]),
        .size       (size_q),
        .is_signed  (sgn_q),
        .old_word   (buf_q),
        .new_data   (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // Next-state and memory-port drive; write enable is decoded from state
    // so an async reset kills it in the same instant.
    always_comb begin
        state_d = state_q;
        mem_we  = 1'b0;
        mem_wd  = '0;
        case (state_q)
            IDLE: begin
                if (accept)
                    state_d = req_bad ? RESP : ACCESS;
            end
            ACCESS: begin
                if (we_q && is_sub) begin
                    state_d = MERGE;
                end else begin
                    if (we_q) begin
                        mem_we = 1'b1;
                        mem_wd = wdata_q;
                    end
                    state_d = RESP;
                end
            end
            MERGE: begin
                mem_we  = 1'b1;
                mem_wd  = merge_data;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Request latch, load-data capture and RMW buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            size_q  <= SIZE_BYTE;
            sgn_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            buf_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            we_q    <= req_we;
            size_q  <= req_size;
            sgn_q   <= req_signed;
            addr_q  <= req_addr[WIDX_W+1:0];
            wdata_q <= req_wdata;
            err_q   <= req_bad;
            rdata_q <= '0;
        end else if (state_q == ACCESS) begin
            if (!we_q)
                rdata_q <= load_data;
            else if (is_sub)
                buf_q <= mem_rd;
        end
    end

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Self-checking bench: behavioural memory model plus a per-cycle monitor
// comparing responses and memory writes against the model's expectations.
module tb_data_mem_access_unit;

    localparam int DEPTH = 64;
    localparam int WW    = 6;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_signed;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [WW-1:0] mem_addr;
    logic [31:0]   mem_wd;
    logic          mem_we;
    logic [31:0]   mem_rd;

    logic [31:0] mem       [DEPTH];
    logic [31:0] model_mem [DEPTH];

    logic          bd_en;
    logic [WW-1:0] bd_addr;
    logic [31:0]   bd_data;

    int n_checks;
    int n_fail;
    int wr_count;
    int resp_count;

    bit            exp_store;
    bit            exp_err;
    logic [31:0]   exp_rdata;
    logic [WW-1:0] exp_waddr;
    logic [31:0]   exp_wdata;
    logic [WW-1:0] last_waddr;
    logic [31:0]   last_wd;

    data_mem_access_unit #(.MEM_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = mem[mem_addr];

    always @(posedge clk) begin
        if (bd_en)
            mem[bd_addr] <= bd_data;
        else if (mem_we)
            mem[mem_addr] <= mem_wd;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    // Specification-level reference: byte-addressed access on a word array.
    function automatic void model_op(input bit we, input logic [1:0] size, input bit sgn,
                                     input logic [31:0] addr, input logic [31:0] wdata,
                                     output bit err, output logic [31:0] rdata,
                                     output logic [31:0] nw, output bit wr);
        int unsigned sh;
        logic [31:0] old, mask, v;
        err = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
              (size == 2'd2 && addr[1:0] != 2'd0) || ((addr >> 2) >= 32'(DEPTH));
        rdata = 32'h0;
        nw    = 32'h0;
        wr    = 1'b0;
        if (!err) begin
            old  = model_mem[addr[7:2]];
            sh   = 8 * 32'(addr[1:0]);
            mask = (size == 2'd0) ? 32'hFF : (size == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
            if (!we) begin
                v = (old >> sh) & mask;
                if (sgn && size == 2'd0 && v >= 32'd128)   v = v + 32'hFFFF_FF00;
                if (sgn && size == 2'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
                rdata = v;
            end else begin
                mask = mask << sh;
                nw   = (old & ~mask) | ((wdata << sh) & mask);
                wr   = 1'b1;
            end
        end
    endfunction

    // Per-cycle compare of memory-port and response outputs against expectations.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!mem_we) begin
                chk("mem_wd_zero_without_we", mem_wd, 32'h0);
            end else begin
                wr_count++;
                last_waddr = mem_addr;
                last_wd    = mem_wd;
                chk("unexpected_write", {31'b0, mem_we}, {31'b0, exp_store});
                chk("write_addr", {26'b0, mem_addr}, {26'b0, exp_waddr});
                chk("write_data", mem_wd, exp_wdata);
            end
            if (resp_valid) begin
                resp_count++;
                chk("resp_err", {31'b0, resp_err}, {31'b0, exp_err});
                chk("resp_rdata", resp_rdata, exp_rdata);
            end
        end
    end

    task automatic preload(input int idx, input logic [31:0] data);
        bd_addr = WW'(idx);
        bd_data = data;
        bd_en   = 1'b1;
        @(posedge clk);
        #1;
        bd_en = 1'b0;
        model_mem[idx] = data;
    endtask

    task automatic set_expect(input bit we, input logic [1:0] size, input bit sgn,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output bit e_err, output bit e_wr);
        logic [31:0] e_rd, e_new;
        model_op(we, size, sgn, addr, wdata, e_err, e_rd, e_new, e_wr);
        exp_store = e_wr;
        exp_err   = e_err;
        exp_rdata = e_rd;
        exp_waddr = addr[7:2];
        exp_wdata = e_new;
        if (e_wr) model_mem[addr[7:2]] = e_new;
    endtask

    task automatic do_req(input bit we, input logic [1:0] size, input bit sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] got_rdata, output bit got_err);
        bit e_err, e_wr, acc, got;
        int lat_exp, edges, wr0;
        set_expect(we, size, sgn, addr, wdata, e_err, e_wr);
        lat_exp = e_err ? 2 : ((we && size != 2'd2) ? 4 : 3);
        wr0 = wr_count;
        req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (req_ready) acc = 1'b1;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        chk("accept_timeout", {31'b0, acc}, 32'h1);
        edges = 1; got = 1'b0; got_rdata = 32'h0; got_err = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                got = 1'b1;
                got_rdata = resp_rdata;
                got_err = resp_err;
            end
            @(posedge clk);
            #1;
            edges++;
        end
        chk("resp_timeout", {31'b0, got}, 32'h1);
        chk("latency_edges", 32'(edges), 32'(lat_exp));
        @(negedge clk);
        chk("resp_single_pulse", {31'b0, resp_valid}, 32'h0);
        chk("ready_after_resp", {31'b0, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        chk("write_count", 32'(wr_count - wr0), e_wr ? 32'h1 : 32'h0);
        if (!e_err) chk("mem_word", mem[addr[7:2]], model_mem[addr[7:2]]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        bit          e;
        int          wr0, rc0, acc_n, idx;
        bit          r_ready, s_err, s_wr;
        bit          s_we   [4];
        logic [1:0]  s_size [4];
        bit          s_sgn  [4];
        logic [31:0] s_addr [4];
        logic [31:0] s_wd   [4];

        n_checks = 0; n_fail = 0; wr_count = 0; resp_count = 0;
        exp_store = 1'b0; exp_err = 1'b0; exp_rdata = 32'h0; exp_waddr = '0; exp_wdata = 32'h0;
        last_waddr = '0; last_wd = 32'h0;
        bd_en = 1'b0; bd_addr = '0; bd_data = 32'h0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        rst_n = 1'b0;
        #2;
        chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
        chk("rst_mem_addr", {26'b0, mem_addr}, 32'h0);
        chk("rst_mem_wd", mem_wd, 32'h0);

        @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) preload(i, $urandom);
        preload(5, 32'h8844_22F1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Sub-word loads from a known word.
        do_req(1'b0, 2'd0, 1'b0, 32'h15, 32'h0, r, e);
        chk("lb_0x15", r, 32'h0000_0022);
        do_req(1'b0, 2'd0, 1'b1, 32'h14, 32'h0, r, e);
        chk("lb_signed_0x14", r, 32'hFFFF_FFF1);
        do_req(1'b0, 2'd0, 1'b0, 32'h14, 32'h0, r, e);
        chk("lbu_0x14", r, 32'h0000_00F1);

        // Byte store RMW then read-back.
        do_req(1'b1, 2'd0, 1'b0, 32'h17, 32'hABCD_EF5A, r, e);
        chk("sb_merge_addr", {26'b0, last_waddr}, 32'd5);
        chk("sb_merge_wd", last_wd, 32'h5A44_22F1);
        do_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, r, e);
        chk("lw_after_sb", r, 32'h5A44_22F1);

        // Word store, half store into upper lane, signed half load.
        do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEAD_BEEF, r, e);
        chk("sw_addr", {26'b0, last_waddr}, 32'd8);
        chk("sw_wd", last_wd, 32'hDEAD_BEEF);
        do_req(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_1234, r, e);
        chk("sh_word8", mem[8], 32'h1234_BEEF);
        do_req(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, r, e);
        chk("lh_signed_0x22", r, 32'h0000_1234);

        // Error cases.
        do_req(1'b0, 2'd2, 1'b0, 32'h02, 32'h0, r, e);
        chk("lw_misaligned_err", {31'b0, e}, 32'h1);
        do_req(1'b0, 2'd1, 1'b0, 32'h01, 32'h0, r, e);
        chk("lh_misaligned_err", {31'b0, e}, 32'h1);
        do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'h1111_2222, r, e);
        chk("sw_range_err", {31'b0, e}, 32'h1);
        do_req(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, r, e);
        chk("size3_err", {31'b0, e}, 32'h1);
        chk("size3_rdata", r, 32'h0);

        // Reset during MERGE of a byte store.
        preload(5, 32'h8844_22F1);
        wr0 = wr_count; rc0 = resp_count;
        exp_store = 1'b0; exp_err = 1'b0;
        req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h17; req_wdata = 32'h11;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("merge_we_before_reset", {31'b0, mem_we}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("reset_drops_we", {31'b0, mem_we}, 32'h0);
        chk("reset_drops_wd", mem_wd, 32'h0);
        chk("reset_no_resp", {31'b0, resp_valid}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {31'b0, req_ready}, 32'h1);
        chk("no_resp_after_reset", {31'b0, resp_valid}, 32'h0);
        @(posedge clk);
        #1;
        chk("reset_word_unchanged", mem[5], 32'h8844_22F1);
        chk("reset_no_write", 32'(wr_count - wr0), 32'h0);
        chk("reset_no_resp_count", 32'(resp_count - rc0), 32'h0);

        // Continuous req_valid with alternating loads and stores.
        s_we[0] = 1'b0; s_size[0] = 2'd2; s_sgn[0] = 1'b0; s_addr[0] = 32'h34; s_wd[0] = 32'h0;
        s_we[1] = 1'b1; s_size[1] = 2'd0; s_sgn[1] = 1'b0; s_addr[1] = 32'h35; s_wd[1] = $urandom;
        s_we[2] = 1'b0; s_size[2] = 2'd1; s_sgn[2] = 1'b1; s_addr[2] = 32'h34; s_wd[2] = 32'h0;
        s_we[3] = 1'b1; s_size[3] = 2'd1; s_sgn[3] = 1'b0; s_addr[3] = 32'h36; s_wd[3] = $urandom;
        wr0 = wr_count; rc0 = resp_count; acc_n = 0; idx = 0;
        req_we = s_we[0]; req_size = s_size[0]; req_signed = s_sgn[0];
        req_addr = s_addr[0]; req_wdata = s_wd[0];
        req_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            r_ready = req_ready;
            @(posedge clk);
            #1;
            if (r_ready && req_valid) begin
                set_expect(s_we[idx], s_size[idx], s_sgn[idx], s_addr[idx], s_wd[idx], s_err, s_wr);
                acc_n++;
                idx++;
                if (idx < 4) begin
                    req_we = s_we[idx]; req_size = s_size[idx]; req_signed = s_sgn[idx];
                    req_addr = s_addr[idx]; req_wdata = s_wd[idx];
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        chk("stream_accepts", 32'(acc_n), 32'd4);
        chk("stream_responses", 32'(resp_count - rc0), 32'd4);
        chk("stream_writes", 32'(wr_count - wr0), 32'd2);
        chk("stream_word13", mem[13], model_mem[13]);

        // Randomized traffic, including out-of-range and illegal sizes.
        for (int k = 0; k < 60; k++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 271));
            if ($urandom_range(0, 9) == 0) a = $urandom;
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   a, $urandom, r, e);
        end

        for (int i = 0; i < DEPTH; i++) chk("final_mem", mem[i], model_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
